pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter stage that consumes the jump unit's target (J_output) and the
//  branch comparator's result, and holds the architectural PC.
//  Issues one instruction-memory fetch request per accepted cycle via a valid/ready handshake.
//  Selects the next PC and traps on misaligned control-flow targets.
// PARAMETERS
//  XLEN          32            datapath/PC width
//  RESET_VECTOR  32'h0000_0000 PC value loaded on reset
//  JALR_CLR_LSB  1             1: clear bit0 of the jump target when io_jmp_is_jalr=1
// PORTS
//  clock            in   1     single clock, rising edge
//  reset            in   1     asynchronous, active-high
//  io_J_output      in   XLEN  jump target from the jump unit
//  io_jmp_en        in   1     current instruction is JAL/JALR (use io_J_output)
//  io_jmp_is_jalr   in   1     jump is JALR (LSB-clear rule applies)
//  io_br_taken      in   1     conditional branch resolved taken
//  io_br_target     in   XLEN  branch target (PC + B-imm)
//  io_stall         in   1     hold PC, suppress request
//  io_imem_ready    in   1     instruction memory accepts request
//  io_imem_valid    out  1     fetch request valid
//  io_imem_addr     out  XLEN  fetch address (= io_pc)
//  io_pc            out  XLEN  current PC
//  io_pc_plus4      out  XLEN  io_pc + 4 (link value for JAL/JALR)
//  io_misaligned    out  1     sticky trap flag
//  io_trap_target   out  XLEN  offending target latched at trap
//  io_fetch_count   out  32    accepted-fetch counter
// BEHAVIOUR
//  Reset (async assert, sync release): state=BOOT, io_pc=RESET_VECTOR, io_imem_valid=0,
//   io_misaligned=0, io_trap_target=0, io_fetch_count=0. Reset mid-operation aborts
//   everything in the same instant; no request survives.
//  FSM states:
//   BOOT: io_imem_valid=0 for exactly one cycle; BOOT->RUN unconditionally.
//   RUN: io_imem_valid = !io_stall. fire = io_imem_valid & io_imem_ready.
//   TRAP: io_imem_valid=0, PC frozen; exit only via reset.
//  Next-PC select (evaluated only on fire), priority:
//   io_jmp_en > io_br_taken > sequential.
//   tgt = io_jmp_en ? (io_J_output & ~(JALR_CLR_LSB & io_jmp_is_jalr)) :
//         io_br_taken ? io_br_target : io_pc + 4.
//   All adds are modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
//  Misalignment: if fire and tgt[1:0] != 0:
//   - state goes RUN->TRAP
//   - io_misaligned=1
//   - io_trap_target=tgt
//   - io_pc unchanged
//   - io_fetch_count still increments (the request was accepted)
//   Sequential tgt is always aligned.
//  Register updates on fire: io_pc<=tgt (if aligned); io_fetch_count<=+1, wraps at 2^32.
//  No fire (stall or !ready): io_pc, counter and state hold. Control inputs must be held
//   stable by upstream until fire; the block does not latch redirects.
//  io_stall=1 with io_imem_ready=1: no fire. Stall takes precedence over ready.
//  io_imem_addr and io_pc_plus4 are combinational from the io_pc register;
//   io_pc_plus4 is valid in every state.
//  Latency: target visible on io_pc/io_imem_addr the cycle after fire.
// TESTING
//  1 Reset, ready=1, no ctrl: valid=0 first cycle, then addr 0,4,8,12; fetch_count=3 after 3 fires.
//  2 At pc=0x10, jmp_en=1, is_jalr=1, J_output=0x41 -> next pc=0x40, no trap; pc_plus4 was 0x14.
//  3 jmp_en=1 and br_taken=1 together, J_output=0x100, br_target=0x200 -> pc=0x100.
//  4 br_taken=1, br_target=0x22 -> TRAP, misaligned=1, trap_target=0x22, pc held, valid=0 until reset.
//  5 stall=1 for 3 cycles with ready=1 -> valid=0, pc/count frozen; ready=0 with stall=0 -> valid=1, pc held.
//  6 Assert reset mid-stream at pc=0x80 -> pc=0 immediately (async), count=0, BOOT cycle repeats.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter stage. It holds the architectural PC and issues one
//   instruction-memory fetch request per cycle over a valid/ready handshake.
//   On every accepted request (fire) it selects the next PC, with priority
//   jump > taken branch > sequential. It traps on a misaligned control-flow
//   target and stays trapped until reset.
//
// Ports
//   clock, reset       rising-edge clock; asynchronous active-high reset
//   io_J_output        jump target from the jump unit
//   io_jmp_en          current instruction is JAL/JALR
//   io_jmp_is_jalr     jump is JALR (bit0 of the target is cleared)
//   io_br_taken        conditional branch resolved taken
//   io_br_target       branch target
//   io_stall           hold PC and suppress the request
//   io_imem_ready      instruction memory accepts the request
//   io_imem_valid      fetch request valid
//   io_imem_addr       fetch address (equals io_pc)
//   io_pc              current PC
//   io_pc_plus4        io_pc + 4, the link value, valid in every state
//   io_misaligned      sticky trap flag
//   io_trap_target     offending target latched at the trap
//   io_fetch_count     count of accepted fetches, wraps at 2^32
module pc_fetch_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = {XLEN{1'b0}},
  parameter bit                JALR_CLR_LSB = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_J_output,
  input  logic            io_jmp_en,
  input  logic            io_jmp_is_jalr,
  input  logic            io_br_taken,
  input  logic [XLEN-1:0] io_br_target,
  input  logic            io_stall,
  input  logic            io_imem_ready,
  output logic            io_imem_valid,
  output logic [XLEN-1:0] io_imem_addr,
  output logic [XLEN-1:0] io_pc,
  output logic [XLEN-1:0] io_pc_plus4,
  output logic            io_misaligned,
  output logic [XLEN-1:0] io_trap_target,
  output logic [31:0]     io_fetch_count
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic            misaligned_r;
  logic [XLEN-1:0] trap_target_r;
  logic [31:0]     fetch_count_r;

  logic            valid_s;
  logic            fire_s;
  logic            tgt_misaligned_s;
  logic [XLEN-1:0] jmp_mask_s;
  logic [XLEN-1:0] tgt_s;

  // Next-PC selection; only consumed on fire. Sequential targets are always aligned.
  always_comb begin
    jmp_mask_s = ~{{(XLEN-1){1'b0}}, (JALR_CLR_LSB & io_jmp_is_jalr)};
    tgt_s      = pc_r + PC_STEP;
    if (io_jmp_en) begin
      tgt_s = io_J_output & jmp_mask_s;
    end else if (io_br_taken) begin
      tgt_s = io_br_target;
    end else begin
      tgt_s = pc_r + PC_STEP;
    end
    tgt_misaligned_s = (tgt_s[1:0] != 2'b00);
  end

  // Request generation and next-state logic.
  always_comb begin
    valid_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        valid_s     = 1'b0;
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        // Stall wins over ready: no request is offered while stalled.
        valid_s = ~io_stall;
        if (valid_s && io_imem_ready && tgt_misaligned_s) begin
          state_nxt_s = ST_TRAP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_TRAP: begin
        valid_s     = 1'b0;
        state_nxt_s = ST_TRAP;
      end
      default: begin
        valid_s     = 1'b0;
        state_nxt_s = ST_BOOT;
      end
    endcase
    fire_s = valid_s & io_imem_ready;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, trap capture and fetch counter; all update only on fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_VECTOR;
      misaligned_r  <= 1'b0;
      trap_target_r <= {XLEN{1'b0}};
      fetch_count_r <= 32'd0;
    end else if (fire_s) begin
      // The request was accepted, so it counts even when it traps.
      fetch_count_r <= fetch_count_r + 32'd1;
      if (tgt_misaligned_s) begin
        misaligned_r  <= 1'b1;
        trap_target_r <= tgt_s;
      end else begin
        pc_r <= tgt_s;
      end
    end
  end

  assign io_imem_valid  = valid_s;
  assign io_imem_addr   = pc_r;
  assign io_pc          = pc_r;
  assign io_pc_plus4    = pc_r + PC_STEP;
  assign io_misaligned  = misaligned_r;
  assign io_trap_target = trap_target_r;
  assign io_fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed scenarios with literal expectations followed by a randomized run.
//   A behavioural model tracks PC, counter and trap status; a negedge compare
//   process checks every DUT output against it each cycle.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_J_output = 32'd0;
  logic        io_jmp_en = 1'b0;
  logic        io_jmp_is_jalr = 1'b0;
  logic        io_br_taken = 1'b0;
  logic [31:0] io_br_target = 32'd0;
  logic        io_stall = 1'b0;
  logic        io_imem_ready = 1'b1;
  logic        io_imem_valid;
  logic [31:0] io_imem_addr;
  logic [31:0] io_pc;
  logic [31:0] io_pc_plus4;
  logic        io_misaligned;
  logic [31:0] io_trap_target;
  logic [31:0] io_fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .io_J_output    (io_J_output),
    .io_jmp_en      (io_jmp_en),
    .io_jmp_is_jalr (io_jmp_is_jalr),
    .io_br_taken    (io_br_taken),
    .io_br_target   (io_br_target),
    .io_stall       (io_stall),
    .io_imem_ready  (io_imem_ready),
    .io_imem_valid  (io_imem_valid),
    .io_imem_addr   (io_imem_addr),
    .io_pc          (io_pc),
    .io_pc_plus4    (io_pc_plus4),
    .io_misaligned  (io_misaligned),
    .io_trap_target (io_trap_target),
    .io_fetch_count (io_fetch_count)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_trapped;
  logic [31:0] m_trap;
  logic        m_booted;   // a full cycle has passed since reset release

  function automatic logic [31:0] model_target();
    logic [31:0] t;
    if (io_jmp_en)
      t = io_is_jalr_clear(io_J_output);
    else if (io_br_taken)
      t = io_br_target;
    else
      t = m_pc + 32'd4;
    return t;
  endfunction

  function automatic logic [31:0] io_is_jalr_clear(input logic [31:0] j);
    // JALR drops bit 0 of the target: round down to an even address.
    if (io_jmp_is_jalr) return (j / 32'd2) * 32'd2;
    else return j;
  endfunction

  function automatic logic model_valid();
    return m_booted && !m_trapped && !io_stall && !reset;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc      <= 32'd0;
      m_count   <= 32'd0;
      m_trapped <= 1'b0;
      m_trap    <= 32'd0;
      m_booted  <= 1'b0;
    end else begin
      m_booted <= 1'b1;
      if (model_valid() && io_imem_ready) begin
        m_count <= m_count + 32'd1;
        if (model_target() % 32'd4 != 32'd0) begin
          m_trapped <= 1'b1;
          m_trap    <= model_target();
        end else begin
          m_pc <= model_target();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clock) begin
    check("m_valid",   {31'd0, io_imem_valid}, {31'd0, model_valid()});
    check("m_addr",    io_imem_addr,   m_pc);
    check("m_pc",      io_pc,          m_pc);
    check("m_pc4",     io_pc_plus4,    m_pc + 32'd4);
    check("m_mis",     {31'd0, io_misaligned}, {31'd0, m_trapped});
    check("m_trap",    io_trap_target, m_trap);
    check("m_count",   io_fetch_count, m_count);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_ctrl();
    io_jmp_en = 1'b0; io_jmp_is_jalr = 1'b0; io_br_taken = 1'b0;
    io_J_output = 32'd0; io_br_target = 32'd0; io_stall = 1'b0; io_imem_ready = 1'b1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v;
    v = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) v = 32'hFFFF_FFF0;
    case ($urandom_range(0, 19))
      0: v = v | 32'd1;
      1: v = v | 32'd2;
      2: v = v | 32'd3;
      default: v = v;
    endcase
    return v;
  endfunction

  initial begin
    // ---- test 1: reset and sequential fetch ----
    clear_ctrl();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(posedge clock); #2; reset = 1'b0;
    check("boot_valid", {31'd0, io_imem_valid}, 32'd0);
    check("boot_pc", io_pc, 32'h0);
    tick(); check("t1_valid", {31'd0, io_imem_valid}, 32'd1);
    check("t1_a0", io_imem_addr, 32'h0);
    tick(); check("t1_a4", io_imem_addr, 32'h4);
    tick(); check("t1_a8", io_imem_addr, 32'h8);
    tick(); check("t1_a12", io_imem_addr, 32'hC);
    check("t1_cnt3", io_fetch_count, 32'd3);
    tick(); check("t2_pc10", io_pc, 32'h10);
    // ---- test 2: JALR clears bit 0 ----
    io_jmp_en = 1'b1; io_jmp_is_jalr = 1'b1; io_J_output = 32'h41;
    #1 check("t2_pc4", io_pc_plus4, 32'h14);
    tick(); check("t2_pc40", io_pc, 32'h40);
    check("t2_nomis", {31'd0, io_misaligned}, 32'd0);
    // ---- test 3: jump beats branch ----
    io_jmp_is_jalr = 1'b0; io_J_output = 32'h100; io_br_taken = 1'b1; io_br_target = 32'h200;
    tick(); check("t3_pc100", io_pc, 32'h100);
    // ---- test 5: stall and not-ready ----
    clear_ctrl(); io_stall = 1'b1;
    #1 check("t5_stall_valid", {31'd0, io_imem_valid}, 32'd0);
    repeat (3) tick();
    check("t5_pc", io_pc, 32'h100);
    check("t5_cnt", io_fetch_count, 32'd6);
    io_stall = 1'b0; io_imem_ready = 1'b0;
    #1 check("t5_nr_valid", {31'd0, io_imem_valid}, 32'd1);
    tick(); check("t5_nr_pc", io_pc, 32'h100);
    // ---- test 4: misaligned branch traps ----
    io_imem_ready = 1'b1; io_br_taken = 1'b1; io_br_target = 32'h22;
    tick(); check("t4_mis", {31'd0, io_misaligned}, 32'd1);
    check("t4_tt", io_trap_target, 32'h22);
    check("t4_pc", io_pc, 32'h100);
    check("t4_cnt", io_fetch_count, 32'd7);
    clear_ctrl();
    repeat (2) tick();
    check("t4_valid", {31'd0, io_imem_valid}, 32'd0);
    // ---- test 6: async reset mid-stream ----
    reset = 1'b1;
    @(posedge clock); #2; reset = 1'b0;
    tick();
    io_jmp_en = 1'b1; io_J_output = 32'h80;
    tick(); clear_ctrl();
    check("t6_pc80", io_pc, 32'h80);
    reset = 1'b1;
    #1 check("t6_pc0", io_pc, 32'h0);
    check("t6_cnt0", io_fetch_count, 32'd0);
    @(posedge clock); #2; reset = 1'b0;
    check("t6_boot", {31'd0, io_imem_valid}, 32'd0);
    tick(); check("t6_run", {31'd0, io_imem_valid}, 32'd1);
    // ---- wrap-around via sequential fetch ----
    io_jmp_en = 1'b1; io_J_output = 32'hFFFF_FFFC;
    tick(); clear_ctrl();
    check("wrap_top", io_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", io_pc_plus4, 32'h0);
    tick(); check("wrap_zero", io_pc, 32'h0);

    // ---- randomized run ----
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) begin
        reset = 1'b0;
      end else if ((m_trapped && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
      end
      io_stall       = ($urandom_range(0, 3) == 0);
      io_imem_ready  = ($urandom_range(0, 3) != 0);
      io_jmp_en      = ($urandom_range(0, 7) == 0);
      io_jmp_is_jalr = $urandom_range(0, 1) == 1;
      io_J_output    = rnd_tgt();
      if (io_jmp_is_jalr && $urandom_range(0, 1) == 1) io_J_output = io_J_output | 32'd1;
      io_br_taken    = ($urandom_range(0, 7) == 0);
      io_br_target   = rnd_tgt();
    end
    reset = 1'b0;
    clear_ctrl();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
